// File: rtl/if_bus_if.sv
// Instruction-fetch Wishbone master: one classic read per fetch, with stall
// handshake to CTRL, a one-word hold buffer for IF/ID stalls, and flush drop.
module if_bus_if #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_INST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic [5:0]        stall_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] inst_o,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [3:0]        wb_sel_o
);

  typedef enum logic [1:0] {IDLE, BUSY, WAIT_STALL} state_t;

  state_t              state, state_nxt;
  logic                cyc;
  logic [ADDR_W-1:0]   adr;
  logic [DATA_W-1:0]   rd_buf;
  logic                if_stall;
  logic                unused_stall;

  assign if_stall     = stall_i[1];
  assign unused_stall = ^{stall_i[5:2], stall_i[0]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (ce_i && !flush_i) state_nxt = BUSY;
      BUSY: begin
        if (flush_i)       state_nxt = IDLE;
        else if (wb_ack_i) state_nxt = if_stall ? WAIT_STALL : IDLE;
      end
      WAIT_STALL: if (flush_i || !if_stall) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Bus registers and hold buffer; flush in BUSY wins over a same-cycle ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc    <= 1'b0;
      adr    <= '0;
      rd_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ce_i && !flush_i) begin
            adr <= pc_i;
            cyc <= 1'b1;
          end
        end
        BUSY: begin
          if (flush_i) begin
            cyc <= 1'b0;
            adr <= '0;
          end else if (wb_ack_i) begin
            cyc <= 1'b0;
            if (if_stall) rd_buf <= wb_dat_i;
          end
        end
        WAIT_STALL: if (flush_i) rd_buf <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    stallreq_o = 1'b0;
    inst_o     = NOP_INST;
    case (state)
      IDLE: stallreq_o = ce_i & ~flush_i;
      BUSY: begin
        stallreq_o = ~wb_ack_i & ~flush_i;
        if (wb_ack_i && !flush_i) inst_o = wb_dat_i;
      end
      WAIT_STALL: inst_o = rd_buf;
      default: ;
    endcase
  end

  assign wb_adr_o = adr;
  assign wb_cyc_o = cyc;
  assign wb_stb_o = cyc;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = cyc ? 4'b1111 : 4'b0000;

endmodule

// File: doc/if_bus_if.md
Name: if_bus_if

Overview:
- Instruction-fetch bus master between the PC stage and the IF/ID pipeline register.
- Takes pc/ce from the PC stage and runs one Wishbone classic read per fetch.
- Asks CTRL to stall the pipeline until the slave acks, then delivers the instruction word to IF/ID.
- Buffers a returned word while IF/ID is stalled, and drops an in-flight fetch on flush.

Parameters:
ADDR_W, 32, width of pc_i and wb_adr_o
DATA_W, 32, instruction/bus data width
NOP_INST, 32'h00000000, value driven on inst_o when no valid word

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
pc_i  input  ADDR_W  fetch address from PC stage
ce_i  input  1  fetch enable from PC stage (1 = fetch)
stall_i  input  6  CTRL stall vector; bit1 = IF stage held
flush_i  input  1  exception flush from CTRL
inst_o  output  DATA_W  instruction to IF/ID (combinational, see below)
stallreq_o  output  1  stall request to CTRL (combinational)
wb_adr_o  output  ADDR_W  Wishbone address (registered)
wb_dat_i  input  DATA_W  Wishbone read data
wb_ack_i  input  1  Wishbone acknowledge
wb_cyc_o  output  1  Wishbone cycle (registered)
wb_stb_o  output  1  Wishbone strobe (registered, equals wb_cyc_o)
wb_we_o  output  1  constant 0 (read only)
wb_sel_o  output  4  4'b1111 while cyc, else 4'b0000

Behaviour:
- Reset: synchronous, active-high. On the rising edge with rst=1:
  - state=IDLE; cyc/stb=0; adr=0; rd_buf=0.
  - Applies mid-transaction too; any pending ack is ignored.
- Outputs after reset: inst_o=NOP_INST; stallreq_o=ce_i&~flush_i.
- States: IDLE, BUSY, WAIT_STALL.
- IDLE:
  - If ce_i & ~flush_i: adr<=pc_i, cyc/stb<=1, go to BUSY.
  - Otherwise stay in IDLE with the bus idle.
- BUSY:
  - flush_i=1 has priority over ack. cyc/stb<=0, adr<=0, go to IDLE; same-cycle ack is discarded.
  - Else if wb_ack_i=1: cyc/stb<=0.
    - If stall_i[1]=1: rd_buf<=wb_dat_i, go to WAIT_STALL.
    - Otherwise go to IDLE.
  - Else stay in BUSY; adr, cyc and stb are held stable.
- WAIT_STALL:
  - flush_i=1: rd_buf<=0, go to IDLE.
  - Else if stall_i[1]=0: go to IDLE.
  - Otherwise stay and hold rd_buf.
- stallreq_o (combinational):
  - IDLE: ce_i & ~flush_i.
  - BUSY: ~wb_ack_i & ~flush_i.
  - WAIT_STALL: 0.
- inst_o (combinational):
  - BUSY & wb_ack_i & ~flush_i: wb_dat_i, same cycle as ack.
  - WAIT_STALL: rd_buf.
  - All other cases: NOP_INST.
- Latency:
  - Request is issued one cycle after pc_i is presented in IDLE.
  - The instruction is valid in the ack cycle, and the PC stage advances on that edge.
  - Zero-wait slave gives 1 instruction per 2 cycles.
- Wishbone rules:
  - stb==cyc at all times.
  - we=0 always.
  - At most one outstanding transaction.
  - A new cycle never starts in the edge that closes the previous one.
- ce_i deasserted in BUSY has no effect; the transaction completes normally.
- Widths: adr is captured unmodified from pc_i; no alignment checking is done.

Test Plan:
- Reset then ce_i=1, pc_i=32'h30000000, slave acks 2nd bus cycle with 32'h3C010101:
  - cyc/stb rise 1 cycle after reset release; wb_adr_o=32'h30000000.
  - stallreq_o=1 until the ack cycle, where stallreq_o=0 and inst_o=32'h3C010101.
  - cyc drops the next cycle.
- Ack with data 32'h34210020 while stall_i=6'b000011 held 3 cycles:
  - WAIT_STALL entered; inst_o=32'h34210020 and stallreq_o=0 for all 3 cycles.
  - IDLE after stall_i[1]=0; a new request follows.
- flush_i=1 during BUSY with wb_ack_i=1 in the same cycle:
  - inst_o=NOP_INST and stallreq_o=0 that cycle.
  - Next cycle cyc=0, state IDLE, data never appears.
- rst=1 asserted in BUSY before ack:
  - Next edge cyc/stb/adr=0 and state IDLE; a late ack yields inst_o=NOP_INST.
- ce_i=0 for 5 cycles from IDLE:
  - No cyc, stallreq_o=0, inst_o=NOP_INST, wb_we_o=0, wb_sel_o=0.
- Back-to-back fetches 0x30000000, 0x30000004 with zero-wait slave:
  - Two cycles with cyc=0 between transactions? No — one idle cycle between transactions.
  - Two instructions delivered in 4 cycles; adr sequence is correct.
